// File: rtl/da_bit_serializer_if.sv
// Load/stream bundle for the DA bit serializer: parallel frame in,
// four bit-plane lines plus mux select and frame markers out.
interface da_bit_serializer_if #(parameter int W = 8);
  localparam int IW = $clog2(W);

  logic          load_valid;
  logic          load_ready;
  logic [W-1:0]  x0, x1, x2, x3;
  logic          en;
  logic          b0, b1, b2, b3;
  logic [1:0]    sel;
  logic [IW-1:0] bit_idx;
  logic          out_valid;
  logic          sop;
  logic          eop;
  logic          sign_bit;

  modport master (
    output load_valid, x0, x1, x2, x3, en,
    input  load_ready, b0, b1, b2, b3, sel, bit_idx, out_valid, sop, eop, sign_bit
  );

  modport slave (
    input  load_valid, x0, x1, x2, x3, en,
    output load_ready, b0, b1, b2, b3, sel, bit_idx, out_valid, sop, eop, sign_bit
  );
endinterface

// File: rtl/da_bit_serializer.sv
// Parallel-to-serial front end for the DA DCT: one-frame holding register
// feeding four LSB-first shift lanes, with mux select and frame markers.
module da_bit_serializer_lane #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic         b
);
  logic [W-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     sr <= '0;
    else if (load)  sr <= d;
    else if (shift) sr <= {1'b0, sr[W-1:1]};
  end

  assign b = sr[0];
endmodule

module da_bit_serializer #(parameter int W = 8) (
  input  logic               clk,
  input  logic               rst_n,
  da_bit_serializer_if.slave bus
);
  localparam int             NUM_LANES = 4;
  localparam int             IW        = $clog2(W);
  localparam logic [IW-1:0]  LAST      = IW'(W - 1);
  localparam logic [0:0]     IDLE      = 1'b0;
  localparam logic [0:0]     SHIFT     = 1'b1;

  logic [0:0]                      state;
  logic                            hold_full;
  logic [NUM_LANES-1:0][W-1:0]     hold, din;
  logic [NUM_LANES-1:0]            bits;
  logic [1:0]                      sel;
  logic [IW-1:0]                   bit_idx;
  logic in_shift, step, plane_end, frame_end, capture, transfer;

  assign din       = {bus.x3, bus.x2, bus.x1, bus.x0};
  assign in_shift  = (state == SHIFT);
  assign step      = in_shift && bus.en;
  assign plane_end = step && (sel == 2'b11);
  assign frame_end = plane_end && (bit_idx == LAST);
  assign capture   = bus.load_valid && !hold_full;
  // IDLE drains the holder regardless of en; in SHIFT only the eop step may.
  assign transfer  = hold_full && (!in_shift || frame_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold      <= '0;
    end else if (capture) begin
      hold      <= din;
      hold_full <= 1'b1;
    end else if (transfer) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel     <= 2'b00;
      bit_idx <= '0;
    end else if (transfer) begin
      state   <= SHIFT;
      sel     <= 2'b00;
      bit_idx <= '0;
    end else if (frame_end) begin
      state   <= IDLE;
      sel     <= 2'b00;
      bit_idx <= '0;
    end else if (step) begin
      sel <= sel + 2'b01;
      if (sel == 2'b11) bit_idx <= bit_idx + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    da_bit_serializer_lane #(.W(W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (transfer),
      .shift (plane_end && !frame_end),
      .d     (hold[g]),
      .b     (bits[g])
    );
  end

  assign bus.load_ready = !hold_full;
  assign bus.b0         = bits[0];
  assign bus.b1         = bits[1];
  assign bus.b2         = bits[2];
  assign bus.b3         = bits[3];
  assign bus.sel        = sel;
  assign bus.bit_idx    = bit_idx;
  assign bus.out_valid  = in_shift;
  assign bus.sop        = in_shift && (bit_idx == '0) && (sel == 2'b00);
  assign bus.eop        = in_shift && (bit_idx == LAST) && (sel == 2'b11);
  assign bus.sign_bit   = in_shift && (bit_idx == LAST);
endmodule

// File: tb/tb_da_bit_serializer.sv
// Directed bench for da_bit_serializer: W=8 and W=4 instances, table-driven
// frame checks plus back-to-back, load-while-full, en-stall and reset cases.
module tb_da_bit_serializer;
  logic clk;
  logic rst_n;
  int   total  = 0;
  int   passed = 0;

  da_bit_serializer_if #(.W(8)) bus8 ();
  da_bit_serializer_if #(.W(4)) bus4 ();

  da_bit_serializer #(.W(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  da_bit_serializer #(.W(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [12:0] exp;   // {out_valid, sop, eop, sign_bit, b3..b0, sel, bit_idx}
  } vec_t;

  typedef struct {
    logic [8:0] exp;    // {out_valid, sop, eop, sign_bit, b0, sel, bit_idx}
  } vec4_t;

  vec_t  tv  [32];
  vec4_t tv4 [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else passed++;
  endtask

  function automatic logic [12:0] out8();
    return {bus8.out_valid, bus8.sop, bus8.eop, bus8.sign_bit,
            bus8.b3, bus8.b2, bus8.b1, bus8.b0, bus8.sel, bus8.bit_idx};
  endfunction

  function automatic logic [8:0] out4();
    return {bus4.out_valid, bus4.sop, bus4.eop, bus4.sign_bit,
            bus4.b0, bus4.sel, bus4.bit_idx};
  endfunction

  // Reference for cycle i of a W=8 frame; xs = {x3, x2, x1, x0}.
  function automatic logic [12:0] exp_vec(input logic [31:0] xs, input int i);
    int p, s;
    p = i / 4;
    s = i % 4;
    return {1'b1, i == 0, i == 31, p == 7,
            xs[24+p], xs[16+p], xs[8+p], xs[p], 2'(s), 3'(p)};
  endfunction

  task automatic drive8(input logic lv, input logic [31:0] xs);
    bus8.load_valid = lv;
    {bus8.x3, bus8.x2, bus8.x1, bus8.x0} = xs;
  endtask

  // Starts checking at the current negedge, which must be the sop cycle.
  task automatic check_frame(input string name, input logic [31:0] xs);
    for (int i = 0; i < 32; i++) begin
      if (i > 0) @(negedge clk);
      chk(name, 32'(out8()), 32'(exp_vec(xs, i)));
    end
    @(negedge clk);
    chk({name, "_after"}, 32'(bus8.out_valid), 32'd0);
  endtask

  initial begin
    logic [3:0] plane_bits [8];
    logic       b0seq4     [4];
    int         idx;

    // {b3,b2,b1,b0} per plane for x0=01, x1=80, x2=FF, x3=5A
    plane_bits = '{4'b0101, 4'b1100, 4'b0100, 4'b1100,
                   4'b1100, 4'b0100, 4'b1100, 4'b0110};
    for (int p = 0; p < 8; p++)
      for (int s = 0; s < 4; s++) begin
        tv[p*4+s].en  = 1'b1;
        tv[p*4+s].exp = {1'b1, p == 0 && s == 0, p == 7 && s == 3, p == 7,
                         plane_bits[p], 2'(s), 3'(p)};
      end
    b0seq4 = '{1'b1, 1'b0, 1'b0, 1'b1};   // 4'h9, LSB first
    for (int p = 0; p < 4; p++)
      for (int s = 0; s < 4; s++)
        tv4[p*4+s].exp = {1'b1, p == 0 && s == 0, p == 3 && s == 3, p == 3,
                          b0seq4[p], 2'(s), 2'(p)};

    rst_n = 1'b0;
    drive8(1'b0, 32'h0);
    bus8.en = 1'b1;
    bus4.load_valid = 1'b0;
    bus4.x0 = '0; bus4.x1 = '0; bus4.x2 = '0; bus4.x3 = '0;
    bus4.en = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_outs", 32'(out8()), 32'd0);
    chk("rst_ready", 32'(bus8.load_ready), 32'd1);
    rst_n = 1'b1;

    // Single frame from the hand table
    @(negedge clk);
    drive8(1'b1, 32'h5AFF8001);
    @(negedge clk);
    drive8(1'b0, 32'h0);
    chk("lat_ready", 32'(bus8.load_ready), 32'd0);
    chk("lat_valid", 32'(bus8.out_valid), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      if (i > 0) @(negedge clk);
      bus8.en = tv[i].en;
      chk($sformatf("frame1[%0d]", i), 32'(out8()), 32'(tv[i].exp));
    end
    @(negedge clk);
    chk("frame1_done", 32'({bus8.out_valid, bus8.load_ready}), 32'b01);

    // Back-to-back A->B, with C offered while B is held
    drive8(1'b1, 32'h5AFF8001);
    @(negedge clk);
    drive8(1'b0, 32'h0);
    @(negedge clk);
    chk("a_sop_ready", 32'({bus8.out_valid, bus8.sop, bus8.load_ready}), 32'b111);
    drive8(1'b1, 32'h7E00C33C);                  // B
    @(negedge clk);
    chk("b_held", 32'(bus8.load_ready), 32'd0);
    drive8(1'b1, 32'hA5A5A5A5);                  // C, must be ignored
    repeat (6) @(negedge clk);
    drive8(1'b0, 32'h0);
    repeat (24) @(negedge clk);
    chk("a_eop_notready", 32'({bus8.out_valid, bus8.eop, bus8.load_ready}), 32'b110);
    @(negedge clk);
    chk("b_sop_nobubble", 32'({bus8.sop, bus8.load_ready}), 32'b11);
    check_frame("frame_b", 32'h7E00C33C);

    // en held low for 3 cycles at plane 1, sel=10
    drive8(1'b1, 32'h12345678);
    @(negedge clk);
    drive8(1'b0, 32'h0);
    @(negedge clk);
    for (int cyc = 0; cyc < 35; cyc++) begin
      if (cyc > 0) @(negedge clk);
      idx = (cyc < 6) ? cyc : (cyc <= 9) ? 6 : cyc - 3;
      chk($sformatf("en_stall[%0d]", cyc), 32'(out8()), 32'(exp_vec(32'h12345678, idx)));
      bus8.en = (cyc < 6 || cyc >= 9);
    end
    @(negedge clk);
    chk("en_stall_len", 32'(bus8.out_valid), 32'd0);

    // Asynchronous reset at bit_idx=3 with a held frame
    drive8(1'b1, 32'h11223344);
    @(negedge clk);
    drive8(1'b0, 32'h0);
    @(negedge clk);
    drive8(1'b1, 32'hFFEEDDCC);
    @(negedge clk);
    drive8(1'b0, 32'h0);
    repeat (11) @(negedge clk);
    chk("pre_rst_pos", 32'({bus8.load_ready, bus8.bit_idx, bus8.sel}), 32'({1'b0, 3'd3, 2'b00}));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outs", 32'(out8()), 32'd0);
    chk("async_rst_ready", 32'(bus8.load_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("no_stale[%0d]", i), 32'({bus8.out_valid, bus8.load_ready}), 32'b01);
    end

    // W=4 instance
    bus4.load_valid = 1'b1;
    bus4.x0 = 4'h9; bus4.x1 = 4'h8; bus4.x2 = 4'h7; bus4.x3 = 4'h1;
    @(negedge clk);
    bus4.load_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("w4[%0d]", i), 32'(out4()), 32'(tv4[i].exp));
    end
    @(negedge clk);
    chk("w4_len", 32'({bus4.out_valid, bus4.load_ready}), 32'b01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
